// File: rtl/map_infl_pkg.sv
// Shared types for the map-inflation window generator.
// MAP_WIN_BORDER_OCC_EN selects an all-ones (obstacle) pad instead of zero (free space).
package map_infl_pkg;

  localparam int CELL_W = 8;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    EOL    = 2'd2,
    FLUSH  = 2'd3
  } state_e;

`ifdef MAP_WIN_BORDER_OCC_EN
  localparam logic  PAD_BIT  = 1'b1;
`else
  localparam logic  PAD_BIT  = 1'b0;
`endif
  localparam cell_t PAD_CELL = {CELL_W{PAD_BIT}};

  // Slice index of neighbour (dr,dc) inside a packed 3x3 window.
  function automatic logic [3:0] win_idx(input int dr, input int dc);
    return 4'((dr + 1) * 3 + (dc + 1));
  endfunction

endpackage

// File: rtl/map_line_buf.sv
// One map row of storage: single write port, asynchronous read port.
// Contents are never reset; every frame rewrites them before they are read.
module map_line_buf #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read sees the old word when read and write hit the same address.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/map_window_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a column shift register.
// Pad value comes from map_infl_pkg (MAP_WIN_BORDER_OCC_EN selects all-ones).
module map_window_gen
  import map_infl_pkg::*;
#(
  parameter int MAP_W  = 64,
  parameter int MAP_H  = 64,
  parameter int CELL_W = 8,
  localparam int COL_W = $clog2(MAP_W),
  localparam int ROW_W = $clog2(MAP_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CELL_W-1:0]   in_cell,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9*CELL_W-1:0] out_win,
  output logic [ROW_W-1:0]    out_row,
  output logic [COL_W-1:0]    out_col
);

  localparam logic [CELL_W-1:0]      PAD      = {CELL_W{PAD_BIT}};
  localparam logic [2:0][CELL_W-1:0] PAD_COL  = {3{PAD}};
  localparam logic [COL_W-1:0]       LAST_COL = COL_W'(MAP_W - 1);
  localparam logic [ROW_W-1:0]       LAST_ROW = ROW_W'(MAP_H - 1);
  localparam logic [ROW_W-1:0]       ROW_ONE  = ROW_W'(1);

  state_e                   r_state, w_state_nxt;
  logic [ROW_W-1:0]         r_row, w_row_nxt;
  logic [COL_W-1:0]         r_col, w_col_nxt;
  logic                     r_out_valid;
  logic [8:0][CELL_W-1:0]   r_win;
  logic [ROW_W-1:0]         r_out_row;
  logic [COL_W-1:0]         r_out_col;
  // Column element [0]=top (dr=-1), [1]=middle, [2]=bottom (dr=+1).
  logic [2:0][CELL_W-1:0]   r_sr1, r_sr2;

  logic                     w_can_load, w_in_ready, w_accept, w_load, w_shift;
  logic [COL_W-1:0]         w_rd_addr;
  logic [CELL_W-1:0]        w_lb1_rd, w_lb2_rd;
  logic [2:0][CELL_W-1:0]   w_cur, w_buf_col;
  logic [2:0][CELL_W-1:0]   w_left, w_mid, w_right, w_sr1_nxt, w_sr2_nxt;
  logic [2:0][2:0][CELL_W-1:0] w_cols;
  logic [8:0][CELL_W-1:0]   w_win;
  logic [ROW_W-1:0]         w_win_row;
  logic [COL_W-1:0]         w_win_col;

  // lb1 holds row r-1, lb2 holds row r-2; accepting a cell ages lb1 into lb2.
  map_line_buf #(.DEPTH(MAP_W), .WIDTH(CELL_W)) u_lb1 (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_col),
    .i_wr_data (in_cell),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_lb1_rd)
  );

  map_line_buf #(.DEPTH(MAP_W), .WIDTH(CELL_W)) u_lb2 (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_col),
    .i_wr_data (w_lb1_rd),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_lb2_rd)
  );

  assign w_can_load = !r_out_valid || out_ready;
  // Incoming column; top is padded while the centre row is row 0.
  assign w_cur      = {in_cell, w_lb1_rd, (r_row == ROW_ONE) ? PAD : w_lb2_rd};
  // Buffered column during flush: bottom row lies below the map.
  assign w_buf_col  = {PAD, w_lb1_rd, w_lb2_rd};

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_rd_addr   = r_col;
    w_left      = r_sr2;
    w_mid       = r_sr1;
    w_right     = PAD_COL;
    w_win_row   = r_row - 1'b1;
    w_win_col   = r_col - 1'b1;
    w_sr2_nxt   = r_sr1;
    w_sr1_nxt   = PAD_COL;
    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        w_accept   = in_valid;
        if (w_accept) begin
          if (r_col == LAST_COL) begin
            w_col_nxt   = '0;
            w_row_nxt   = ROW_ONE;
            w_state_nxt = STREAM;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      STREAM: begin
        w_in_ready = w_can_load;
        w_accept   = in_valid && w_can_load;
        w_right    = w_cur;
        w_sr1_nxt  = w_cur;
        w_sr2_nxt  = (r_col == '0) ? PAD_COL : r_sr1;
        if (w_accept) begin
          w_shift = 1'b1;
          w_load  = (r_col != '0);
          if (r_col == LAST_COL) begin
            w_col_nxt   = '0;
            w_state_nxt = EOL;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      EOL: begin
        w_win_col = LAST_COL;
        w_rd_addr = '0;
        // Preload column 0 of the bottom row's windows in case flush follows.
        w_sr1_nxt = w_buf_col;
        w_sr2_nxt = PAD_COL;
        if (w_can_load) begin
          w_load  = 1'b1;
          w_shift = 1'b1;
          if (r_row == LAST_ROW) begin
            w_state_nxt = FLUSH;
          end else begin
            w_row_nxt   = r_row + 1'b1;
            w_state_nxt = STREAM;
          end
        end
      end
      FLUSH: begin
        w_rd_addr = r_col + 1'b1;
        w_right   = (r_col == LAST_COL) ? PAD_COL : w_buf_col;
        w_sr1_nxt = w_right;
        w_win_row = LAST_ROW;
        w_win_col = r_col;
        if (w_can_load) begin
          w_load  = 1'b1;
          w_shift = 1'b1;
          if (r_col == LAST_COL) begin
            w_col_nxt   = '0;
            w_row_nxt   = '0;
            w_state_nxt = FILL;
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign w_cols = {w_right, w_mid, w_left};

  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign w_win[win_idx(i - 1, j - 1)] = w_cols[j][i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_row       <= '0;
      r_col       <= '0;
      r_sr1       <= '0;
      r_sr2       <= '0;
      r_out_valid <= 1'b0;
      r_win       <= '0;
      r_out_row   <= '0;
      r_out_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      if (w_shift) begin
        r_sr1 <= w_sr1_nxt;
        r_sr2 <= w_sr2_nxt;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_win       <= w_win;
        r_out_row   <= w_win_row;
        r_out_col   <= w_win_col;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready && !rst;
  assign out_valid = r_out_valid;
  assign out_win   = r_win;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;

endmodule

// File: tb/tb_map_window_gen.sv
// Bench for map_window_gen on a 4x3 map: ramp, backpressure, bubbles, mid-frame reset,
// back-to-back and random frames checked against a direct neighbourhood model.
module tb_map_window_gen;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int WH = W * H;
`ifdef MAP_WIN_BORDER_OCC_EN
  localparam logic [7:0] PADV = 8'hFF;
`else
  localparam logic [7:0] PADV = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_cell;
  logic [71:0] out_win;
  logic [1:0]  out_row, out_col;

  map_window_gen #(.MAP_W(W), .MAP_H(H), .CELL_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cell(in_cell),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_win(out_win), .out_row(out_row), .out_col(out_col)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [7:0]  img [2][H][W];
  int          q_row[$], q_col[$];
  logic [71:0] q_win[$];
  int stall_bad, rdy_bad, fill_bad, nrdy, first_in, last_out;

  // Reference: neighbourhood of (R,C) read straight from the frame image.
  function automatic logic [71:0] exp_win(input int f, input int R, input int C);
    logic [71:0] w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = R + dr;
        int c = C + dc;
        logic [7:0] v;
        if (r < 0 || r >= H || c < 0 || c >= W) v = PADV;
        else v = img[f][r][c];
        w[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] = v;
      end
    return w;
  endfunction

  function automatic logic [71:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic set_ramp();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[f][r][c] = 8'(4 * r + c);
  endtask

  task automatic set_rand();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) img[f][r][c] = 8'($urandom);
  endtask

  // rmode: 0 always ready, 1 toggling, 2 random 60%.
  task automatic drive(input int nfr, input int vpct, input int rmode, input int budget,
                       output bit to);
    int in_cnt = 0, out_cnt = 0, tot;
    bit pst = 0, fill;
    logic [71:0] pw = '0;
    logic [1:0]  pr = '0, pc = '0;
    tot = nfr * WH;
    q_row.delete(); q_col.delete(); q_win.delete();
    stall_bad = 0; rdy_bad = 0; fill_bad = 0; nrdy = 0; first_in = -1; last_out = -1;
    for (int cyc = 0; cyc < budget && out_cnt < tot; cyc++) begin
      @(negedge clk);
      in_valid = (in_cnt < tot) && ($urandom_range(99) < vpct);
      if (in_valid) in_cell = img[in_cnt / WH][(in_cnt % WH) / W][in_cnt % W];
      else in_cell = 8'($urandom);
      case (rmode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 2 == 0);
        default: out_ready = ($urandom_range(99) < 60);
      endcase
      #1;
      fill = (in_cnt % WH < W) && (out_cnt + int'(out_valid) >= (in_cnt / WH) * WH);
      if (pst && (out_win !== pw || out_row !== pr || out_col !== pc)) stall_bad++;
      if (out_valid && !out_ready && in_ready && !fill) rdy_bad++;
      if (out_valid && fill && (out_cnt + 1 != (in_cnt / WH) * WH)) fill_bad++;
      if (!in_ready) nrdy++;
      if (in_valid && in_ready) begin
        if (in_cnt == 0) first_in = cyc;
        in_cnt++;
      end
      if (out_valid && out_ready) begin
        q_row.push_back(int'(out_row));
        q_col.push_back(int'(out_col));
        q_win.push_back(out_win);
        last_out = cyc;
        out_cnt++;
      end
      pst = out_valid && !out_ready;
      pw = out_win; pr = out_row; pc = out_col;
    end
    to = (out_cnt < tot);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_cell = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_hs: out_valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    tests++;
    if (out_win !== '0 || out_row !== '0 || out_col !== '0) begin
      fails++; $display("FAIL reset_data: win=%h row=%0d col=%0d, expected zeros", out_win, out_row, out_col);
    end
    rst = 1'b0;
  endtask

  task automatic test_ramp();
    bit to;
    set_ramp();
    drive(1, 100, 0, 200, to);
    tests++;
    if (to || q_win.size() != WH) begin
      fails++; $display("FAIL ramp_count: got %0d windows, expected %0d", q_win.size(), WH);
    end
    for (int i = 0; i < q_win.size(); i++) begin
      tests++;
      if (q_row[i] !== i / W || q_col[i] !== i % W || q_win[i] !== exp_win(0, i / W, i % W)) begin
        fails++; $display("FAIL ramp_win[%0d]: got (%0d,%0d) %h, expected (%0d,%0d) %h",
                          i, q_row[i], q_col[i], q_win[i], i / W, i % W, exp_win(0, i / W, i % W));
      end
    end
    tests++;
    if (last_out - first_in != 18) begin
      fails++; $display("FAIL ramp_latency: got %0d cycles, expected 18", last_out - first_in);
    end
    if (q_win.size() == WH) begin
`ifdef MAP_WIN_BORDER_OCC_EN
      tests++;
      if (q_win[11] !== pk(6, 7, 255, 10, 11, 255, 255, 255, 255)) begin
        fails++; $display("FAIL pad_win23: got %h, expected %h", q_win[11], pk(6, 7, 255, 10, 11, 255, 255, 255, 255));
      end
`else
      tests++;
      if (q_win[5] !== pk(0, 1, 2, 4, 5, 6, 8, 9, 10)) begin
        fails++; $display("FAIL ramp_win11: got %h, expected %h", q_win[5], pk(0, 1, 2, 4, 5, 6, 8, 9, 10));
      end
      tests++;
      if (q_win[0] !== pk(0, 0, 0, 0, 0, 1, 0, 4, 5)) begin
        fails++; $display("FAIL ramp_win00: got %h, expected %h", q_win[0], pk(0, 0, 0, 0, 0, 1, 0, 4, 5));
      end
      tests++;
      if (q_win[11] !== pk(6, 7, 0, 10, 11, 0, 0, 0, 0)) begin
        fails++; $display("FAIL pad_win23: got %h, expected %h", q_win[11], pk(6, 7, 0, 10, 11, 0, 0, 0, 0));
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    bit to;
    set_ramp();
    drive(1, 100, 1, 400, to);
    tests++;
    if (to || q_win.size() != WH) begin
      fails++; $display("FAIL bp_count: got %0d windows, expected %0d", q_win.size(), WH);
    end
    for (int i = 0; i < q_win.size(); i++) begin
      tests++;
      if (q_row[i] !== i / W || q_col[i] !== i % W || q_win[i] !== exp_win(0, i / W, i % W)) begin
        fails++; $display("FAIL bp_win[%0d]: got (%0d,%0d) %h, expected %h", i, q_row[i], q_col[i],
                          q_win[i], exp_win(0, i / W, i % W));
      end
    end
    tests++;
    if (stall_bad != 0) begin
      fails++; $display("FAIL bp_stable: %0d changes while stalled, expected 0", stall_bad);
    end
    tests++;
    if (rdy_bad != 0) begin
      fails++; $display("FAIL bp_in_ready: %0d cycles ready while stalled, expected 0", rdy_bad);
    end
  endtask

  task automatic test_bubbles();
    bit to;
    set_ramp();
    drive(1, 50, 0, 600, to);
    tests++;
    if (to || q_win.size() != WH) begin
      fails++; $display("FAIL bub_count: got %0d windows, expected %0d", q_win.size(), WH);
    end
    for (int i = 0; i < q_win.size(); i++) begin
      tests++;
      if (q_row[i] !== i / W || q_col[i] !== i % W || q_win[i] !== exp_win(0, i / W, i % W)) begin
        fails++; $display("FAIL bub_win[%0d]: got (%0d,%0d) %h, expected %h", i, q_row[i], q_col[i],
                          q_win[i], exp_win(0, i / W, i % W));
      end
    end
    tests++;
    if (fill_bad != 0) begin
      fails++; $display("FAIL bub_fill: %0d windows seen in fill, expected 0", fill_bad);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    set_ramp();
    for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1; in_cell = img[0][n / W][n % W];
      #1;
      if (in_ready) n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (n != 7 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL rstmid_valid: accepted=%0d out_valid=%b in_ready=%b, expected 7 0 0",
                        n, out_valid, in_ready);
    end
    tests++;
    if (out_win !== '0 || out_row !== '0 || out_col !== '0) begin
      fails++; $display("FAIL rstmid_data: win=%h row=%0d col=%0d, expected zeros", out_win, out_row, out_col);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive(1, 100, 0, 200, to);
    tests++;
    if (to || q_win.size() != WH) begin
      fails++; $display("FAIL rstmid_count: got %0d windows, expected %0d", q_win.size(), WH);
    end
    for (int i = 0; i < q_win.size(); i++) begin
      tests++;
      if (q_row[i] !== i / W || q_col[i] !== i % W || q_win[i] !== exp_win(0, i / W, i % W)) begin
        fails++; $display("FAIL rstmid_win[%0d]: got (%0d,%0d) %h, expected %h", i, q_row[i], q_col[i],
                          q_win[i], exp_win(0, i / W, i % W));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    set_ramp();
    drive(2, 100, 0, 300, to);
    tests++;
    if (to || q_win.size() != 2 * WH) begin
      fails++; $display("FAIL b2b_count: got %0d windows, expected %0d", q_win.size(), 2 * WH);
    end
    for (int i = 0; i < q_win.size(); i++) begin
      tests++;
      if (q_row[i] !== (i % WH) / W || q_col[i] !== i % W || q_win[i] !== exp_win(i / WH, (i % WH) / W, i % W)) begin
        fails++; $display("FAIL b2b_win[%0d]: got (%0d,%0d) %h, expected %h", i, q_row[i], q_col[i],
                          q_win[i], exp_win(i / WH, (i % WH) / W, i % W));
      end
    end
    tests++;
    if (nrdy != 12) begin
      fails++; $display("FAIL b2b_not_ready: got %0d cycles, expected 12", nrdy);
    end
    tests++;
    if (last_out - first_in != 36) begin
      fails++; $display("FAIL b2b_duration: got %0d cycles, expected 36", last_out - first_in);
    end
  endtask

  task automatic test_random();
    bit to;
    set_rand();
    drive(2, 50, 2, 2000, to);
    tests++;
    if (to || q_win.size() != 2 * WH) begin
      fails++; $display("FAIL rnd_count: got %0d windows, expected %0d", q_win.size(), 2 * WH);
    end
    for (int i = 0; i < q_win.size(); i++) begin
      tests++;
      if (q_row[i] !== (i % WH) / W || q_col[i] !== i % W || q_win[i] !== exp_win(i / WH, (i % WH) / W, i % W)) begin
        fails++; $display("FAIL rnd_win[%0d]: got (%0d,%0d) %h, expected %h", i, q_row[i], q_col[i],
                          q_win[i], exp_win(i / WH, (i % WH) / W, i % W));
      end
    end
    tests++;
    if (stall_bad != 0 || rdy_bad != 0) begin
      fails++; $display("FAIL rnd_handshake: stall changes %0d, ready-while-stalled %0d, expected 0 0",
                        stall_bad, rdy_bad);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/map_window_gen.md
# map_window_gen

Streaming 3x3 neighbourhood generator for the map-inflation pipeline. It accepts occupancy-grid cells in raster order over a valid/ready handshake, buffers two map rows, and emits one 3x3 window per map cell, centred on that cell, with out-of-map positions padded. It sits directly upstream of the inflation kernel. The kernel's sideband coordinates are carried alongside its datapath through fixed-latency `delay` stages.

## Interface
- `MAP_W`, 64: cells per row (>= 2)
- `MAP_H`, 64: rows per frame (>= 2)
- `CELL_W`, 8: bits per cell
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `in_valid` in 1: input cell valid
- `in_ready` out 1: block accepts the cell this cycle
- `in_cell` in CELL_W: cell value, raster order (row 0 col 0 first)
- `out_valid` out 1: window valid
- `out_ready` in 1: downstream accepts the window
- `out_win` out 9*CELL_W: window; slice k = (dr+1)*3+(dc+1), dr/dc in {-1,0,1}, k=0 in LSBs
- `out_row` out $clog2(MAP_H): centre row
- `out_col` out $clog2(MAP_W): centre column

## Operation
- Window centred (R,C): cell (R+dr, C+dc). Out-of-map positions take the pad value (see Configuration).
- Each frame emits exactly MAP_H*MAP_W windows in raster order of centre.
- States: FILL, STREAM, EOL, FLUSH.
- FILL (reset state): accepts row 0 and emits nothing. After accepting (0,MAP_W-1), moves to STREAM.
- STREAM, accepting input (r,c) with c>=1: loads the window centred (r-1,c-1). Accepting (r,0) loads nothing.
- STREAM, after accepting (r,MAP_W-1): moves to EOL.
- EOL: in_ready=0. Loads the window centred (r-1,MAP_W-1) with the right column padded. Then returns to STREAM, or enters FLUSH if r=MAP_H-1.
- FLUSH: in_ready=0. Emits the windows centred (MAP_H-1,0..MAP_W-1) from the line buffers, with the bottom row padded. After the last handshake, returns to FILL for the next frame.
- Window loads: a new window loads into the output register only when `!out_valid || out_ready`. in_ready in FILL is 1. In STREAM, in_ready = `!out_valid || out_ready`.
- Line buffers hold rows r-1 and r-2. A 3x3 column shift register supplies the horizontal neighbours. A column reset pads the left column at C=0.
- Output stability: while `out_valid && !out_ready`, out_win, out_row and out_col are held unchanged.

## Timing
- Reset values: out_valid=0, out_win=0, out_row=0, out_col=0, in_ready=0 while rst is asserted, state=FILL, all counters 0.
- Line-buffer contents are not reset; row 0 of every frame overwrites them before use.
- Latency: the window appears on the cycle after the accepting input handshake.
- Throughput: with out_ready=1 and in_valid=1 continuously, one window per cycle, with no bubbles in EOL or FLUSH.
- Frame duration: the last window of a frame is valid MAP_H*MAP_W + (MAP_H-1) + MAP_W cycles after the first input handshake.
- rst mid-frame: outputs return to reset values asynchronously. The first input after deassertion is treated as (0,0).
- Simultaneous out_ready and input handshake in STREAM: the old window retires and the new one loads in the same cycle.

## Configuration
- `MAP_WIN_BORDER_OCC_EN` defined: the pad value is all-ones, so map edges act as obstacles and inflate inward.
- Not defined: the pad value is zero (free space).
- Only the pad constant differs; timing is identical in both builds.

## Structure
- `map_infl_pkg` holds:
  - `cell_t` (CELL_W-bit cell)
  - the state enum
  - `PAD_CELL` constant, selected by the macro
  - the window index helper function
- Sub-module `map_line_buf`: a MAP_W-deep, CELL_W-wide row buffer with one write and one read per cycle, instantiated twice.
- Counters and the FSM stay in `map_window_gen`.

## Test plan
- Ramp frame: MAP_W=4, MAP_H=3, in_cell = 4r+c, out_ready=1, macro off.
  - Required: 12 windows in raster order.
  - Window (1,1) = {0,1,2,4,5,6,8,9,10}.
  - Window (0,0) = {0,0,0,0,0,1,0,4,5}.
  - Last window valid 18 cycles after the first handshake.
- Edge padding: same frame with MAP_WIN_BORDER_OCC_EN defined.
  - Required: window (2,3) = {6,7,255,10,11,255,255,255,255} (CELL_W=8).
- Backpressure: out_ready toggles 1/0 each cycle.
  - Required: out_win, out_row and out_col are stable while stalled.
  - in_ready=0 whenever out_valid=1 and out_ready=0 in STREAM.
  - No window is lost or duplicated.
- Input bubbles: in_valid is random at 50%.
  - Required: window sequence and contents identical to the ramp case.
  - No window emitted in FILL.
- Reset mid-frame: assert rst after 7 input handshakes, then send a full frame.
  - Required: out_valid=0 immediately after assertion.
  - Next frame's windows match the ramp case exactly.
- Back-to-back frames: two ramp frames sent continuously.
  - Required: 24 windows.
  - in_ready=0 for exactly the 2 EOL cycles and 4 FLUSH cycles per frame.
